// File: rtl/note_scheduler_pkg.sv
// Shared note-key table, scheduler state encoding and timing helpers.
package note_scheduler_pkg;

  localparam int NUM_KEYS = 12;

  // z s x d c v g b h n j m
  localparam logic [7:0] NOTE_KEYS [NUM_KEYS] = '{
    8'h7A, 8'h73, 8'h78, 8'h64, 8'h63, 8'h76,
    8'h67, 8'h62, 8'h68, 8'h6E, 8'h6A, 8'h6D
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_PLAY,
    ST_GAP
  } state_t;

  function automatic logic is_note_key(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit = hit | (code == NOTE_KEYS[i]);
    end
    return hit;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned frq, input int unsigned ms);
    return (frq / 1000) * ms;
  endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Key, sequence-ROM and note-output signals between the scheduler and its neighbours.
interface note_scheduler_if #(
  parameter int unsigned C_SEQ_LEN = 16
);
  localparam int ADDR_W = $clog2(C_SEQ_LEN);

  logic [7:0]        inKey;
  logic              inKeyValid;
  logic              inSeqEn;
  logic [ADDR_W-1:0] outSeqAddr;
  logic [7:0]        inSeqData;
  logic [7:0]        outNote;
  logic              outNoteOn;
  logic              outSrc;

  modport master (
    output inKey, inKeyValid, inSeqEn, inSeqData,
    input  outSeqAddr, outNote, outNoteOn, outSrc
  );

  modport slave (
    input  inKey, inKeyValid, inSeqEn, inSeqData,
    output outSeqAddr, outNote, outNoteOn, outSrc
  );
endinterface

// File: rtl/note_scheduler_timer.sv
// Loadable down-counter; done_o is high during the last cycle of a loaded interval.
module note_scheduler_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/note_scheduler.sv
// Chooses the sounding note: live key presses pre-empt a looping demo sequence
// fetched from an external ROM, with fixed hold and gap timing.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ = 100000000,
  parameter int unsigned C_HOLD_MS = 250,
  parameter int unsigned C_GAP_MS  = 20,
  parameter int unsigned C_SEQ_LEN = 16
) (
  input  logic            clk,
  input  logic            rstb,
  note_scheduler_if.slave bus
);

  localparam int unsigned HOLD_CYC = ms_to_cycles(C_CLK_FRQ, C_HOLD_MS);
  localparam int unsigned GAP_CYC  = ms_to_cycles(C_CLK_FRQ, C_GAP_MS);
  localparam int unsigned MAX_CYC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  // One extra value of headroom so a load that is an exact power of two still fits.
  localparam int          TMR_W    = $clog2(MAX_CYC + 1);
  localparam int          ADDR_W   = $clog2(C_SEQ_LEN);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYC);

  state_t            state_q, state_d;
  logic [7:0]        note_q, note_d;
  logic              on_q, on_d;
  logic              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;

  logic [NUM_KEYS-1:0] key_match;
  logic [NUM_KEYS-1:0] rom_match;
  logic                key_hit;
  logic                rom_note;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_match
      assign key_match[gi] = (bus.inKey == NOTE_KEYS[gi]);
      assign rom_match[gi] = (bus.inSeqData == NOTE_KEYS[gi]);
    end
  endgenerate

  assign key_hit  = bus.inKeyValid & (|key_match);
  assign rom_note = |rom_match;

  note_scheduler_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rstb       (rstb),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      note_q  <= 8'h00;
      on_q    <= 1'b0;
      src_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      on_q    <= on_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
    end
  end

  // A valid live key overrides every state, including a pending ROM fetch.
  always_comb begin
    state_d = state_q;
    if (key_hit) begin
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_IDLE:       if (bus.inSeqEn) state_d = ST_FETCH;
        ST_FETCH:      state_d = ST_FETCH_WAIT;
        ST_FETCH_WAIT: state_d = ST_PLAY;
        ST_PLAY:       if (tmr_done) state_d = ST_GAP;
        ST_GAP:        if (tmr_done) state_d = bus.inSeqEn ? ST_FETCH : ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    note_d   = note_q;
    on_d     = on_q;
    src_d    = src_q;
    addr_d   = addr_q;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;

    if (state_q == ST_IDLE && !bus.inSeqEn) begin
      addr_d = '0;
    end

    if (key_hit) begin
      note_d   = bus.inKey;
      on_d     = 1'b1;
      src_d    = 1'b0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: on_d = 1'b0;
        ST_FETCH_WAIT: begin
          // Zero or any non-note code is a rest: keep the last note, gate off.
          src_d    = 1'b1;
          tmr_load = 1'b1;
          if (rom_note) begin
            note_d = bus.inSeqData;
            on_d   = 1'b1;
          end else begin
            on_d   = 1'b0;
          end
        end
        ST_PLAY: begin
          if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
            on_d     = 1'b0;
          end
        end
        ST_GAP: begin
          // A live note resumes at the current address; only a sequence note advances it.
          if (tmr_done) begin
            if (bus.inSeqEn && src_q) begin
              addr_d = addr_q + 1'b1;
            end else if (!bus.inSeqEn) begin
              addr_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.outNote    = note_q;
  assign bus.outNoteOn  = on_q;
  assign bus.outSrc     = src_q;
  assign bus.outSeqAddr = addr_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Cycle-accurate checks of the note scheduler with 1 ms = 1 clock, hold 5, gap 2, 4-entry ROM.
module tb_note_scheduler;

  typedef struct {
    bit         kv;
    logic [7:0] key;
    bit         seqen;
    int         n;
    logic [7:0] note;
    bit         on;
    bit         src;
    logic [1:0] addr;
  } vec_t;

  typedef struct {
    logic [7:0] note;
    bit         on;
    bit         src;
    logic [1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  note_scheduler_if #(.C_SEQ_LEN(4)) bus ();

  note_scheduler #(
    .C_CLK_FRQ (1000),
    .C_HOLD_MS (5),
    .C_GAP_MS  (2),
    .C_SEQ_LEN (4)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  logic [7:0] rom [4] = '{8'h7A, 8'h00, 8'h78, 8'h6D};
  always @(posedge clk) bus.inSeqData <= rom[bus.outSeqAddr];

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic void add(bit kv, logic [7:0] key, bit seqen, int n,
                              logic [7:0] note, bit on, bit src, logic [1:0] addr);
    vec_t v;
    v.kv = kv; v.key = key; v.seqen = seqen; v.n = n;
    v.note = note; v.on = on; v.src = src; v.addr = addr;
    tbl.push_back(v);
  endfunction

  task automatic check_exp(input string name, input exp_t e);
    checks++;
    if (bus.outNote !== e.note || bus.outNoteOn !== e.on ||
        bus.outSrc !== e.src || bus.outSeqAddr !== e.addr) begin
      errors++;
      $display("FAIL %s: got note=%02h on=%0d src=%0d addr=%0d, want note=%02h on=%0d src=%0d addr=%0d",
               name, bus.outNote, bus.outNoteOn, bus.outSrc, bus.outSeqAddr,
               e.note, e.on, e.src, e.addr);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    for (int c = 0; c < v.n; c++) begin
      @(negedge clk);
      bus.inKeyValid = (c == 0) ? v.kv : 1'b0;
      bus.inKey      = v.key;
      bus.inSeqEn    = v.seqen;
      e.note = v.note; e.on = v.on; e.src = v.src; e.addr = v.addr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check_exp($sformatf("vec%0d.c%0d", idx, c), got);
    end
    $display("vec %0d: kv=%0d key=%02h seqen=%0d cycles=%0d", idx, v.kv, v.key, v.seqen, v.n);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    exp_t zero;
    bit   found;
    zero.note = 8'h00; zero.on = 1'b0; zero.src = 1'b0; zero.addr = 2'd0;

    rstb = 1'b0;
    bus.inKey = 8'h00;
    bus.inKeyValid = 1'b0;
    bus.inSeqEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_exp("reset_state", zero);
    @(negedge clk);
    rstb = 1'b1;

    // Live note: hold 5, gap 2, then idle.
    add(1, 8'h7A, 0, 5, 8'h7A, 1, 0, 0);
    add(0, 8'h00, 0, 2, 8'h7A, 0, 0, 0);
    add(0, 8'h00, 0, 2, 8'h7A, 0, 0, 0);
    // Invalid code ignored; retrigger mid-hold; invalid strobe mid-hold ignored.
    add(1, 8'h41, 0, 10, 8'h7A, 0, 0, 0);
    add(1, 8'h7A, 0, 3, 8'h7A, 1, 0, 0);
    add(1, 8'h6D, 0, 2, 8'h6D, 1, 0, 0);
    add(1, 8'h41, 0, 3, 8'h6D, 1, 0, 0);
    add(0, 8'h00, 0, 2, 8'h6D, 0, 0, 0);
    add(0, 8'h00, 0, 2, 8'h6D, 0, 0, 0);
    // Sequence through all four entries and wrap.
    add(0, 8'h00, 1, 2, 8'h6D, 0, 0, 0);
    add(0, 8'h00, 1, 5, 8'h7A, 1, 1, 0);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 0);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 1);
    add(0, 8'h00, 1, 5, 8'h7A, 0, 1, 1);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 1);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 2);
    add(0, 8'h00, 1, 5, 8'h78, 1, 1, 2);
    add(0, 8'h00, 1, 2, 8'h78, 0, 1, 2);
    add(0, 8'h00, 1, 2, 8'h78, 0, 1, 3);
    add(0, 8'h00, 1, 5, 8'h6D, 1, 1, 3);
    add(0, 8'h00, 1, 2, 8'h6D, 0, 1, 3);
    add(0, 8'h00, 1, 2, 8'h6D, 0, 1, 0);
    add(0, 8'h00, 1, 5, 8'h7A, 1, 1, 0);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 0);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 1);
    add(0, 8'h00, 1, 5, 8'h7A, 0, 1, 1);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 1);
    add(0, 8'h00, 1, 2, 8'h7A, 0, 1, 2);
    // Pre-emption during addr-2 play, then resume with a re-fetch of addr 2.
    add(0, 8'h00, 1, 2, 8'h78, 1, 1, 2);
    add(1, 8'h63, 1, 5, 8'h63, 1, 0, 2);
    add(0, 8'h00, 1, 2, 8'h63, 0, 0, 2);
    add(0, 8'h00, 1, 2, 8'h63, 0, 0, 2);
    add(0, 8'h00, 1, 5, 8'h78, 1, 1, 2);
    add(0, 8'h00, 1, 2, 8'h78, 0, 1, 2);
    add(0, 8'h00, 1, 2, 8'h78, 0, 1, 3);
    add(0, 8'h00, 1, 5, 8'h6D, 1, 1, 3);
    add(0, 8'h00, 1, 2, 8'h6D, 0, 1, 3);
    // Key coincident with gap expiry: live wins, address stays at 3.
    add(1, 8'h62, 1, 5, 8'h62, 1, 0, 3);
    add(0, 8'h00, 1, 2, 8'h62, 0, 0, 3);
    add(0, 8'h00, 1, 2, 8'h62, 0, 0, 3);
    add(0, 8'h00, 1, 5, 8'h6D, 1, 1, 3);
    // Sequence disabled: gap finishes, then idle with address cleared.
    add(0, 8'h00, 0, 2, 8'h6D, 0, 1, 3);
    add(0, 8'h00, 0, 4, 8'h6D, 0, 1, 0);
    run_table();

    // Asynchronous reset while playing addr 2.
    @(negedge clk);
    bus.inSeqEn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.outSeqAddr == 2'd2 && bus.outNoteOn) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_addr2_play: got addr=%0d on=%0d, want addr=2 on=1 within 40 cycles",
               bus.outSeqAddr, bus.outNoteOn);
    end
    @(negedge clk);
    #2;
    rstb = 1'b0;
    #1;
    check_exp("async_reset", zero);
    @(negedge clk);
    bus.inSeqEn = 1'b0;
    rstb = 1'b1;

    add(0, 8'h00, 0, 5, 8'h00, 0, 0, 0);
    add(1, 8'h73, 0, 5, 8'h73, 1, 0, 0);
    add(0, 8'h00, 0, 2, 8'h73, 0, 0, 0);
    add(0, 8'h00, 0, 2, 8'h73, 0, 0, 0);
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion within 20000 cycles");
    $fatal(1, "timeout");
  end

endmodule
